// File: rtl/cnt_seq_checker_if.sv
// Bundle between the upstream count source and the sequence checker.
// The checker drives the status/statistics side; the source drives cnt_in and clr.
interface cnt_seq_checker_if #(
  parameter int CNT_W  = 2,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
);
  logic [CNT_W-1:0]  cnt_in;
  logic              clr;
  logic [1:0]        state;
  logic              locked;
  logic              err_pulse;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;

  modport master (
    output cnt_in, clr,
    input  state, locked, err_pulse, err_sticky, err_count, wrap_pulse, wrap_count
  );

  modport slave (
    input  cnt_in, clr,
    output state, locked, err_pulse, err_sticky, err_count, wrap_pulse, wrap_count
  );
endinterface

// File: rtl/cnt_seq_checker.sv
// Monitors a free-running counter for strict +1 steps: acquires lock after a run
// of good steps, then counts wrap-arounds and sequence errors (saturating).
module cnt_seq_checker #(
  parameter int CNT_W       = 2,
  parameter int LOCK_CYCLES = 2,
  parameter int WRAP_W      = 8,
  parameter int ERR_W       = 4
) (
  input  logic                clk,
  input  logic                reset,
  cnt_seq_checker_if.slave    mon
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   prev_q;
  logic [3:0]         streak_q, streak_d;
  logic               locked_q;
  logic               err_pulse_q, err_pulse_d;
  logic               err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]  wrap_count_q, wrap_count_d;

  logic [CNT_W-1:0]   prev_inc;
  logic [3:0]         streak_inc;
  logic               good;
  logic               err_ev;
  logic               wrap_ev;

  assign prev_inc   = prev_q + CNT_W'(1);
  assign streak_inc = streak_q + 4'd1;
  assign good       = (mon.cnt_in == prev_inc);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    err_ev   = 1'b0;
    wrap_ev  = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d  = ACQ;
        streak_d = '0;
      end
      ACQ: begin
        // mismatches while acquiring only restart the streak; they are not errors
        if (good) begin
          if (streak_inc == LOCK_N) begin
            state_d  = LOCK;
            streak_d = '0;
          end else begin
            streak_d = streak_inc;
          end
        end else begin
          streak_d = '0;
        end
      end
      LOCK: begin
        if (!good) begin
          err_ev   = 1'b1;
          state_d  = ACQ;
          streak_d = '0;
        end else if ((prev_q == '1) && (mon.cnt_in == '0)) begin
          wrap_ev = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        streak_d = '0;
      end
    endcase

    err_pulse_d  = err_ev;
    wrap_pulse_d = wrap_ev;

    // clr wins over a coincident event for the statistics, pulses still fire
    if (mon.clr) begin
      err_count_d  = '0;
      wrap_count_d = '0;
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q | err_ev;
      err_count_d  = (err_ev && (err_count_q != '1)) ? err_count_q + ERR_W'(1) : err_count_q;
      wrap_count_d = (wrap_ev && (wrap_count_q != '1)) ? wrap_count_q + WRAP_W'(1) : wrap_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      streak_q     <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= mon.cnt_in;
      streak_q     <= streak_d;
      locked_q     <= (state_d == LOCK);
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign mon.state      = state_q;
  assign mon.locked     = locked_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.err_sticky = err_sticky_q;
  assign mon.err_count  = err_count_q;
  assign mon.wrap_pulse = wrap_pulse_q;
  assign mon.wrap_count = wrap_count_q;

endmodule
